// File: rtl/imm_encoder.sv
// imm_encoder
//   Sequential search for a data-processing immediate encoding. Finds the
//   smallest rot such that value == {24'b0, imm8} << (ROT_STEP*rot), trying one
//   rot per cycle, or reports that no encoding exists.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   start  in   request, sampled only while idle
//   value  in   32-bit constant to encode, captured on an accepted start
//   busy   out  high while searching or presenting a result
//   done   out  one-cycle pulse when ok/imm8/rot are valid
//   ok     out  1 = encodable, 0 = no (imm8, rot) exists
//   imm8   out  encoded 8-bit immediate
//   rot    out  encoded rotate field
module imm_encoder #(
    parameter int unsigned ROT_STEP = 4,
    parameter int unsigned MAX_ROT  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [7:0]  imm8,
    output logic [3:0]  rot
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] MISS   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] val_q, val_d;
    logic        ok_d;
    logic [7:0]  imm8_d;
    logic [3:0]  rot_d;

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] low_mask;
    logic        fit;
    logic        last;

    // Shift stays below 32 because cnt never exceeds MAX_ROT.
    assign shamt    = 5'(ROT_STEP * 32'(cnt_q));
    assign shifted  = val_q >> shamt;
    assign low_mask = (32'h1 << shamt) - 32'h1;
    assign fit      = ((shifted & ~32'hFF) == 32'h0) && ((val_q & low_mask) == 32'h0);
    assign last     = (cnt_q == 3'(MAX_ROT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        ok_d    = ok;
        imm8_d  = imm8;
        rot_d   = rot;
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = value;
                    cnt_d   = 3'd0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (fit) begin
                    ok_d    = 1'b1;
                    imm8_d  = shifted[7:0];
                    rot_d   = {1'b0, cnt_q};
                    state_d = DONE;
                end else if (last) begin
                    state_d = MISS;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            // A miss takes one extra cycle so a failed search completes at a
            // fixed MAX_ROT+3, one cycle after the slowest possible hit.
            MISS: begin
                ok_d    = 1'b0;
                imm8_d  = 8'h00;
                rot_d   = 4'h0;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            val_q   <= 32'h0;
            ok      <= 1'b0;
            imm8    <= 8'h00;
            rot     <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            ok      <= ok_d;
            imm8    <= imm8_d;
            rot     <= rot_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [7:0]  imm8;
    logic [3:0]  rot;

    int total;
    int bad;

    imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ok    (ok),
        .imm8  (imm8),
        .rot   (rot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        e_ok;
        logic [7:0]  e_imm;
        logic [3:0]  e_rot;
        int          e_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Smallest r with value divisible by 16^r and quotient below 256.
    function automatic void model(input logic [31:0] v, output logic m_ok,
                                  output logic [7:0] m_imm, output logic [3:0] m_rot,
                                  output int m_lat);
        longint unsigned p;
        longint unsigned x;
        x = {32'b0, v};
        m_ok = 1'b0; m_imm = 8'h0; m_rot = 4'h0; m_lat = 9;
        for (int r = 6; r >= 0; r--) begin
            p = 64'd1 << (4 * r);
            if ((x % p) == 0 && (x / p) < 256) begin
                m_ok = 1'b1; m_imm = 8'(x / p); m_rot = 4'(r); m_lat = r + 2;
            end
        end
    endfunction

    // Start in cycle 0, watch cycles 1..14 at the falling edge.
    task automatic run(input logic [31:0] v, output int lat, output logic r_ok,
                       output logic [7:0] r_imm, output logic [3:0] r_rot, output int pulses);
        @(negedge clk);
        value = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; value = $urandom;
        lat = -1; pulses = 0; r_ok = 1'bx; r_imm = 8'hx; r_rot = 4'hx;
        for (int c = 1; c <= 14; c++) begin
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; r_ok = ok; r_imm = imm8; r_rot = rot;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_vec(input string tag, input logic [31:0] v, input logic e_ok,
                             input logic [7:0] e_imm, input logic [3:0] e_rot, input int e_lat);
        int lat, pulses;
        logic r_ok;
        logic [7:0] r_imm;
        logic [3:0] r_rot;
        run(v, lat, r_ok, r_imm, r_rot, pulses);
        if (lat < 0) chk({tag, " timeout"}, 0, 1);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " pulses"}, pulses, 1);
        chk({tag, " ok"}, r_ok, e_ok);
        chk({tag, " imm8"}, r_imm, e_imm);
        chk({tag, " rot"}, r_rot, e_rot);
        chk({tag, " hold"}, {ok, imm8, rot}, {e_ok, e_imm, e_rot});
        if (r_ok === 1'b1)
            chk({tag, " reextend"}, ({24'b0, r_imm} << (4 * r_rot)), v);
    endtask

    initial begin
        logic [31:0] rv;
        logic        m_ok;
        logic [7:0]  m_imm;
        logic [3:0]  m_rot;
        int          m_lat;
        int          lat, pulses;
        total = 0; bad = 0;

        vecs[0] = '{32'h000000AB, 1'b1, 8'hAB, 4'd0, 2};
        vecs[1] = '{32'h00AB0000, 1'b1, 8'hAB, 4'd4, 6};
        vecs[2] = '{32'hF0000000, 1'b1, 8'hF0, 4'd6, 8};
        vecs[3] = '{32'h00000101, 1'b0, 8'h00, 4'd0, 9};
        vecs[4] = '{32'h0000ABC0, 1'b0, 8'h00, 4'd0, 9};
        vecs[5] = '{32'h00000000, 1'b1, 8'h00, 4'd0, 2};

        reset = 1'b1; start = 1'b0; value = 32'h0;
        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset outs", {ok, imm8, rot}, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            check_vec($sformatf("vec%0d", i), vecs[i].v, vecs[i].e_ok, vecs[i].e_imm,
                      vecs[i].e_rot, vecs[i].e_lat);

        // Random sweep: half built to be encodable, half arbitrary.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) rv = {24'b0, 8'($urandom)} << (4 * $urandom_range(0, 7));
            else if (i % 4 == 1) rv = $urandom & (32'hFFF << (4 * $urandom_range(0, 5)));
            else rv = $urandom;
            model(rv, m_ok, m_imm, m_rot, m_lat);
            check_vec($sformatf("rand%0d", i), rv, m_ok, m_imm, m_rot, m_lat);
        end

        // start during SEARCH is ignored.
        @(negedge clk);
        value = 32'h00AB0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        value = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; pulses = 0;
        for (int c = 3; c <= 14; c++) begin
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    chk("busy-start result", {ok, imm8, rot}, {1'b1, 8'hAB, 4'd4});
                end
            end
            @(negedge clk);
        end
        chk("busy-start latency", lat, 6);
        chk("busy-start pulses", pulses, 1);

        // Reset mid-search aborts with no done.
        @(negedge clk);
        value = 32'h00AB0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort outs", {done, ok, imm8, rot}, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        chk("abort no done", pulses, 0);
        check_vec("after-reset", 32'h00AB0000, 1'b1, 8'hAB, 4'd4, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
